spi_bus_master: RTL and testbench
=================================

# spi_bus_master

SPI master that issues the two-frame bus transactions decoded by the board's SPI slave/bus bridge: writes of a data byte to a 7-bit address and reads of a byte from a 7-bit address. It sits on the host/controller side of the SPI link. It converts a single-cycle `start` request into framed SPI traffic (ss_l, sclk, mosi) and returns read data captured from miso. It is the initiator counterpart of the slave-side decoder feeding the bar LEDs, switches and RAM.

## Interface
- `CLK_DIV`, default 4: clk cycles per sclk half-period; legal range 2..255.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_l` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe; accepted only when `busy`=0.
- `rw` input 1: 1 = READ, 0 = WRITE; sampled with `start`.
- `addr` input [7:1]: target bus address; sampled with `start`.
- `wr_data` input [8:1]: write data; sampled with `start`.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse at transaction end.
- `rd_data` output [8:1]: last read result.
- `ss_l` output 1: slave select, active low.
- `sclk` output 1: SPI clock, idle low.
- `mosi` output 1: master out, bit 8 first.
- `miso` input 1: slave out.

## Operation
- Reset values: `busy`=0, `done`=0, `rd_data`=8'h00, `ss_l`=1, `sclk`=0, `mosi`=0.
- Frame 1, command: `{rw, addr[7:1]}`.
- Frame 2, WRITE: `wr_data`.
- Frame 2, READ: command byte repeated as dummy. miso bits captured in frame 2 form `rd_data`. miso in frame 1 is discarded.
- SPI mode 0: mosi changes only while sclk low; miso sampled on the clk edge that ends each sclk-high half-period; MSB (bit 8) first.
- Inputs are registered on acceptance. Later changes to `rw`/`addr`/`wr_data` have no effect on the transaction in progress.
- States:
  - IDLE → SETUP on `start` & !busy.
  - SETUP (ss_l=0, sclk=0, mosi=bit 8) → SHIFT.
  - SHIFT (16 half-periods, sclk high first) → GAP.
  - GAP (ss_l=1, sclk=0) → SETUP if frame 1, else IDLE with `done`.
- Counters: half-period divider 0..CLK_DIV-1; bit counter 0..7; frame flag 0/1. No wrap beyond 8 bits: the shift register is 8 bits, and bits 9+ cannot occur.
- `start` while `busy`=1 is ignored (not queued).
- `start` asserted in the same cycle as `done` is ignored. It is accepted the following cycle if still high.
- `rd_data` is updated only at `done` of a READ. WRITE leaves it unchanged.
- Reset mid-transaction: all outputs return immediately to reset values and the partial frame is abandoned. The slave side sees ss_l rise, and the next frame starts clean.

## Timing
- Cycle 0: `start` sampled high. Cycle 1: `busy`=1, `ss_l`=0, `mosi`=frame bit 8.
- SETUP: CLK_DIV cycles, sclk low.
- SHIFT: sclk toggles every CLK_DIV cycles, high first, 8 full periods (16*CLK_DIV cycles).
  - mosi advances to the next bit in the same cycle sclk goes low.
  - sclk ends low.
- ss_l rises the cycle after SHIFT ends. Frame ss_l-low time = 17*CLK_DIV cycles.
- GAP: 2*CLK_DIV cycles, ss_l=1.
- Transaction: 38*CLK_DIV cycles from the cycle after acceptance to the `done` cycle (152 at CLK_DIV=4).
- `done`=1 and `busy`=0 in the same cycle. `rd_data` is valid in that cycle.
- Two ss_l assertions per transaction. The slave commits a WRITE at the next ss_l fall (start of the next transaction), which is expected.

## Test plan
- Reset: hold rst_l=0 mid-SHIFT of a READ → ss_l=1, sclk=0, mosi=0, busy=0, done=0, rd_data=8'h00 within the same cycle. After release, IDLE until start.
- WRITE addr=7'h02, wr_data=8'hA5, CLK_DIV=4:
  - Frame 1 mosi = 8'h02, frame 2 mosi = 8'hA5, MSB first.
  - Two ss_l pulses of 68 cycles each.
  - done at cycle 152.
  - rd_data unchanged.
- READ addr=7'h01, slave model returns 8'h3C in frame 2 → frame 1 and frame 2 mosi both = 8'h81, rd_data=8'h3C at done.
- CLK_DIV=2 READ returning 8'hFF then READ returning 8'h00 back-to-back: start held high continuously → second transaction accepted the cycle after done. rd_data = 8'hFF, then 8'h00.
- start pulsed at cycles 5 and 40 of a transaction → ignored, exactly 2 frames issued, single done pulse.
- Protocol checker throughout: mosi never changes while sclk=1; sclk=0 whenever ss_l=1; exactly 8 sclk rising edges per ss_l-low window.

Source files
------------

// File: rtl/spi_bus_master.sv
// spi_bus_master: SPI mode-0 initiator for the two-frame bus protocol of the
// board's SPI slave/bus bridge. One transaction is a command frame {rw, addr}
// followed by a data frame: wr_data for a WRITE, or the command byte repeated
// as a dummy for a READ. The byte the slave returns during that second frame
// becomes rd_data.
//
// Ports:
//   clk, rst_l          system clock, asynchronous active-low reset
//   start, rw, addr,    request strobe and its operands; these are captured
//   wr_data             when start is accepted
//   busy, done          transaction in progress, one-cycle completion pulse
//   rd_data             result of the most recent READ
//   ss_l, sclk, mosi,   SPI link
//   miso
module spi_bus_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       start,
    input  logic       rw,
    input  logic [7:1] addr,
    input  logic [8:1] wr_data,
    output logic       busy,
    output logic       done,
    output logic [8:1] rd_data,
    output logic       ss_l,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST_F1 = CNT_W'(2 * CLK_DIV - 1);
    // The final gap is one cycle shorter: the done cycle itself (ss_l high)
    // completes the 2*CLK_DIV deselect time.
    localparam logic [CNT_W-1:0] GAP_LAST_F2 = CNT_W'(2 * CLK_DIV - 2);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_half;
    logic [3:0]       w_half_nxt;
    logic             r_frame;
    logic [7:0]       r_cmd;
    logic [7:0]       r_wdat;
    logic [7:0]       r_tx;
    logic [7:0]       w_tx_nxt;
    logic [7:0]       r_rx;
    logic             r_busy, r_done, r_ss_l, r_sclk, r_mosi;
    logic [7:0]       r_rd;
    logic             w_busy_nxt, w_done_nxt, w_ss_l_nxt, w_sclk_nxt, w_mosi_nxt;
    logic [7:0]       w_rd_nxt;

    logic w_accept;
    logic w_div_end;
    logic w_gap_end;
    logic w_fall;

    // A start seen during the done cycle is ignored.
    assign w_accept  = start & (r_state == S_IDLE) & ~r_done;
    assign w_div_end = (r_cnt == DIV_LAST);
    assign w_gap_end = (r_cnt == (r_frame ? GAP_LAST_F2 : GAP_LAST_F1));
    // This edge ends an sclk-high half: miso is sampled and mosi advances.
    assign w_fall    = (r_state == S_SHIFT) & w_div_end & ~r_half[0];

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
            S_SETUP: if (w_div_end) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_div_end && r_half == 4'd15) w_state_nxt = S_GAP;
            S_GAP:   if (w_gap_end) w_state_nxt = r_frame ? S_IDLE : S_SETUP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the counters and the transmit shifter.
    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_state_nxt != r_state || r_state == S_IDLE ||
            (r_state == S_SHIFT && w_div_end))
            w_cnt_nxt = '0;

        w_half_nxt = r_half;
        if (r_state == S_SETUP)
            w_half_nxt = '0;
        else if (r_state == S_SHIFT && w_div_end)
            w_half_nxt = r_half + 4'd1;

        w_tx_nxt = r_tx;
        if (w_accept)
            w_tx_nxt = {rw, addr};
        else if (r_state == S_GAP && w_gap_end && !r_frame)
            w_tx_nxt = r_cmd[7] ? r_cmd : r_wdat;
        else if (w_fall)
            w_tx_nxt = {r_tx[6:0], 1'b0};
    end

    // Output logic, evaluated for the upcoming cycle so every output is a flop.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_GAP) && (w_state_nxt == S_IDLE);
        w_ss_l_nxt = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
        w_sclk_nxt = (w_state_nxt == S_SHIFT) && !w_half_nxt[0];
        w_mosi_nxt = w_ss_l_nxt ? 1'b0 : w_tx_nxt[7];
        w_rd_nxt   = (w_done_nxt && r_cmd[7]) ? r_rx : r_rd;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt   <= '0;
            r_half  <= '0;
            r_frame <= 1'b0;
            r_cmd   <= '0;
            r_wdat  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_half <= w_half_nxt;
            r_tx   <= w_tx_nxt;
            if (w_accept) begin
                r_frame <= 1'b0;
                r_cmd   <= {rw, addr};
                r_wdat  <= wr_data;
            end else if (r_state == S_GAP && w_gap_end) begin
                r_frame <= 1'b1;
            end
            // Frame-1 bits shift out of the 8-bit register during frame 2.
            if (w_fall) r_rx <= {r_rx[6:0], miso};
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ss_l <= 1'b1;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_rd   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_ss_l <= w_ss_l_nxt;
            r_sclk <= w_sclk_nxt;
            r_mosi <= w_mosi_nxt;
            r_rd   <= w_rd_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_data = r_rd;
    assign ss_l    = r_ss_l;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_bus_master.sv
// tb_spi_bus_master: directed and random transactions on two masters
// (CLK_DIV=4 and CLK_DIV=2). Each master has a behavioural SPI slave, and the
// CLK_DIV=4 master also has a frame monitor.
module tb_spi_bus_master;
    localparam int unsigned D4 = 4;
    localparam int unsigned D2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       rst4_l, start4, rw4, busy4, done4, ss4_l, sclk4, mosi4, miso4;
    logic [6:0] addr4;
    logic [7:0] wd4, rd4;
    logic       rst2_l, start2, rw2, busy2, done2, ss2_l, sclk2, mosi2, miso2;
    logic [6:0] addr2;
    logic [7:0] wd2, rd2;

    spi_bus_master #(.CLK_DIV(D4)) u_dut4 (
        .clk(clk), .rst_l(rst4_l), .start(start4), .rw(rw4), .addr(addr4),
        .wr_data(wd4), .busy(busy4), .done(done4), .rd_data(rd4),
        .ss_l(ss4_l), .sclk(sclk4), .mosi(mosi4), .miso(miso4)
    );

    spi_bus_master #(.CLK_DIV(D2)) u_dut2 (
        .clk(clk), .rst_l(rst2_l), .start(start2), .rw(rw2), .addr(addr2),
        .wr_data(wd2), .busy(busy2), .done(done2), .rd_data(rd2),
        .ss_l(ss2_l), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave responses: frame 1 returns junk, frame 2 returns the read byte.
    logic [7:0] s4_resp, s4_junk, s2_resp, s2_junk;

    // Slave model and protocol monitor for the CLK_DIV=4 master.
    logic [7:0] cap4 [0:63];
    int         n4 = 0;
    logic       p4_ss_l = 1'b1, p4_sclk = 1'b0, p4_mosi = 1'b0;
    logic [7:0] sl4_sh = 8'h00;
    logic       sl4_frame = 1'b0;
    int         rises4 = 0, low4 = 0;
    logic [7:0] msh4 = 8'h00;

    always @(negedge clk) begin
        if (!rst4_l) begin
            sl4_frame = 1'b0;
            miso4     = 1'b0;
        end else begin
            if (!ss4_l && p4_ss_l) begin
                sl4_sh    = sl4_frame ? s4_resp : s4_junk;
                sl4_frame = ~sl4_frame;
                miso4     = sl4_sh[7];
            end else if (!sclk4 && p4_sclk) begin
                sl4_sh = {sl4_sh[6:0], 1'b0};
                miso4  = sl4_sh[7];
            end
            if (ss4_l) chk("sclk_low_when_deselected", 32'(sclk4), 0);
            if (p4_sclk && sclk4) chk("mosi_stable_sclk_high", 32'(mosi4), 32'(p4_mosi));
            if (!ss4_l && p4_ss_l) begin
                rises4 = 0;
                low4   = 0;
            end
            if (!ss4_l) low4++;
            if (sclk4 && !p4_sclk) begin
                rises4++;
                msh4 = {msh4[6:0], mosi4};
            end
            if (ss4_l && !p4_ss_l) begin
                chk("sclk_rises_per_frame", rises4, 8);
                chk("ss_l_low_cycles", low4, 17 * D4);
                cap4[6'(n4)] = msh4;
                n4++;
            end
        end
        p4_ss_l = ss4_l;
        p4_sclk = sclk4;
        p4_mosi = mosi4;
    end

    // Slave model for the CLK_DIV=2 master.
    logic       p2_ss_l = 1'b1, p2_sclk = 1'b0;
    logic [7:0] sl2_sh = 8'h00;
    logic       sl2_frame = 1'b0;

    always @(negedge clk) begin
        if (!rst2_l) begin
            sl2_frame = 1'b0;
            miso2     = 1'b0;
        end else if (!ss2_l && p2_ss_l) begin
            sl2_sh    = sl2_frame ? s2_resp : s2_junk;
            sl2_frame = ~sl2_frame;
            miso2     = sl2_sh[7];
        end else if (!sclk2 && p2_sclk) begin
            sl2_sh = {sl2_sh[6:0], 1'b0};
            miso2  = sl2_sh[7];
        end
        p2_ss_l = ss2_l;
        p2_sclk = sclk2;
    end

    // Reference value of rd_data for the CLK_DIV=4 master.
    logic [7:0] m_rd4 = 8'h00;

    // One full transaction on the CLK_DIV=4 master, with optional stray starts.
    task automatic run4(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] resp, input bit pulses);
        int n0, ndone, tdone;
        logic [7:0] f1, f2;
        f1 = {rw, a};
        f2 = rw ? f1 : wd;
        s4_resp = resp;
        s4_junk = 8'($urandom);
        n0 = n4;
        ndone = 0;
        tdone = -1;
        @(negedge clk);
        rw4 = rw; addr4 = a; wd4 = wd; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        rw4 = ~rw; addr4 = 7'($urandom); wd4 = 8'($urandom);
        chk("cycle1_busy", 32'(busy4), 1);
        chk("cycle1_ss_l", 32'(ss4_l), 0);
        chk("cycle1_mosi", 32'(mosi4), 32'(rw));
        for (int cyc = 1; cyc <= 40 * D4; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done4) begin
                ndone++;
                if (tdone < 0) begin
                    tdone = cyc;
                    chk("done_with_busy_low", 32'(busy4), 0);
                    if (rw) m_rd4 = resp;
                    chk("rd_data_at_done", 32'(rd4), 32'(m_rd4));
                end
            end
            start4 = pulses && (cyc == 5 || cyc == 40);
        end
        start4 = 1'b0;
        chk("done_cycle", tdone, 38 * D4);
        chk("done_pulses", ndone, 1);
        chk("frames_issued", n4 - n0, 2);
        chk("frame1_mosi", 32'(cap4[6'(n0)]), 32'(f1));
        chk("frame2_mosi", 32'(cap4[6'(n0 + 1)]), 32'(f2));
        chk("rd_data_after", 32'(rd4), 32'(m_rd4));
    endtask

    initial begin
        int   t;
        bit   found;
        rst4_l = 1'b0; rst2_l = 1'b0;
        start4 = 1'b0; rw4 = 1'b0; addr4 = '0; wd4 = '0;
        start2 = 1'b0; rw2 = 1'b0; addr2 = '0; wd2 = '0;
        s4_resp = '0; s4_junk = '0; s2_resp = '0; s2_junk = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy4), 0);
        chk("reset_done", 32'(done4), 0);
        chk("reset_rd_data", 32'(rd4), 0);
        chk("reset_ss_l", 32'(ss4_l), 1);
        chk("reset_sclk", 32'(sclk4), 0);
        chk("reset_mosi", 32'(mosi4), 0);
        rst4_l = 1'b1;
        rst2_l = 1'b1;
        repeat (2) @(negedge clk);

        run4(1'b0, 7'h02, 8'hA5, 8'h5A, 1'b0);
        run4(1'b1, 7'h01, 8'h00, 8'h3C, 1'b0);
        run4(1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        run4(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        for (int i = 0; i < 4; i++)
            run4(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        run4(1'b1, 7'h55, 8'h00, 8'hC3, 1'b0);

        // Reset in the middle of frame 1 of a READ.
        s4_resp = 8'h99;
        s4_junk = 8'($urandom);
        @(negedge clk);
        rw4 = 1'b1; addr4 = 7'h11; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3 * D4) @(negedge clk);
        chk("pre_reset_sclk_active", 32'(ss4_l), 0);
        #2 rst4_l = 1'b0;
        #1;
        m_rd4 = 8'h00;
        chk("midreset_ss_l", 32'(ss4_l), 1);
        chk("midreset_sclk", 32'(sclk4), 0);
        chk("midreset_mosi", 32'(mosi4), 0);
        chk("midreset_busy", 32'(busy4), 0);
        chk("midreset_done", 32'(done4), 0);
        chk("midreset_rd_data", 32'(rd4), 32'(m_rd4));
        repeat (2) @(negedge clk);
        rst4_l = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle_ss_l", 32'(ss4_l), 1);
        chk("post_reset_idle_busy", 32'(busy4), 0);
        run4(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 1'b0);

        // Back-to-back READs at CLK_DIV=2 with start held high.
        s2_resp = 8'hFF;
        s2_junk = 8'($urandom);
        @(negedge clk);
        rw2 = 1'b1; addr2 = 7'($urandom); start2 = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (done2) found = 1'b1;
        end
        chk("b2b_first_done_seen", 32'(found), 1);
        chk("b2b_first_rd_data", 32'(rd2), 32'h0FF);
        chk("b2b_done_busy_low", 32'(busy2), 0);
        s2_resp = 8'h00;
        @(negedge clk);
        chk("b2b_start_ignored_at_done", 32'(busy2), 0);
        @(negedge clk);
        chk("b2b_accepted_next_cycle", 32'(busy2), 1);
        t = 2;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            t++;
            if (done2) found = 1'b1;
        end
        start2 = 1'b0;
        chk("b2b_second_done_seen", 32'(found), 1);
        chk("b2b_done_interval", t, 38 * D2 + 1);
        chk("b2b_second_rd_data", 32'(rd2), 32'h000);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
